mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, requester IDs, latched command.
// No logic; imported by the arbiter and its round-robin sub-block.
package mem_arbiter_pkg;

   localparam int TCNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational (zero latency, no backpressure).
// grant[0] = fetch, grant[1] = data; a tie goes to whoever was not granted last.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       req_if,
   input  logic       req_d,
   input  req_id_t    last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req_if && req_d) begin
         grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
      end else if (req_if) begin
         grant = 2'b01;
      end else if (req_d) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory port; grant in N, mem_req N+1.., done one cycle after ack/timeout.
// Requesters are held off by withholding grant while a transaction is in flight; memory stalls via late ack up to TIMEOUT.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_done,
   output logic [31:0] o_if_rdata,
   input  logic        i_d_req,
   input  logic        i_d_we,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   input  logic [3:0]  i_d_be,
   output logic        o_d_gnt,
   output logic        o_d_done,
   output logic [31:0] o_d_rdata,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ack,
   output logic        o_err
);

   state_t            state, state_nxt;
   req_id_t           last_grant, owner;
   mem_cmd_t          cmd, grant_cmd;
   logic [TCNT_W-1:0] tcnt;
   logic              err_flag;
   logic [1:0]        grant;
   logic              timeout_hit;
   logic              finish;

   rr_arb2 u_rr (
      .req_if     (i_if_req),
      .req_d      (i_d_req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Hitting TIMEOUT-1 without ack means this is the TIMEOUT-th ACCESS cycle.
   assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT - 1));
   assign finish      = i_mem_ack || timeout_hit;

   always_comb begin
      grant_cmd.addr  = i_if_addr;
      grant_cmd.we    = 1'b0;
      grant_cmd.be    = 4'hF;
      grant_cmd.wdata = 32'h0;
      if (grant[1]) begin
         grant_cmd.addr  = i_d_addr;
         grant_cmd.we    = i_d_we;
         grant_cmd.be    = i_d_be;
         grant_cmd.wdata = i_d_wdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (grant != 2'b00) state_nxt = ST_ACCESS;
         ST_ACCESS: if (finish) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         last_grant <= REQ_D;
         owner      <= REQ_IF;
         cmd        <= '0;
         tcnt       <= '0;
         err_flag   <= 1'b0;
         o_if_rdata <= '0;
         o_d_rdata  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  owner      <= grant[1] ? REQ_D : REQ_IF;
                  last_grant <= grant[1] ? REQ_D : REQ_IF;
                  cmd        <= grant_cmd;
                  tcnt       <= '0;
                  err_flag   <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (finish) begin
                  err_flag <= !i_mem_ack;
                  if (owner == REQ_D) o_d_rdata  <= i_mem_ack ? i_mem_rdata : 32'h0;
                  else                o_if_rdata <= i_mem_ack ? i_mem_rdata : 32'h0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Reset gating keeps every handshake output low during the reset cycle itself.
   assign o_if_gnt    = !i_reset && (state == ST_IDLE) && grant[0];
   assign o_d_gnt     = !i_reset && (state == ST_IDLE) && grant[1];
   assign o_mem_req   = !i_reset && (state == ST_ACCESS);
   assign o_if_done   = !i_reset && (state == ST_RESP) && (owner == REQ_IF);
   assign o_d_done    = !i_reset && (state == ST_RESP) && (owner == REQ_D);
   assign o_err       = !i_reset && (state == ST_RESP) && err_flag;
   assign o_mem_addr  = cmd.addr;
   assign o_mem_we    = cmd.we;
   assign o_mem_be    = cmd.be;
   assign o_mem_wdata = cmd.wdata;

endmodule
